// File: rtl/native_bus_decoder.sv
// Address decoder/response controller between a native memory master and NUM_SLAVES slaves.
// Latency: 2 cycles minimum for a mapped access (+1 per slave wait state), 1 cycle for an unmapped one.
// Backpressure: slaves stall via s_ready; a slave stalled for TIMEOUT cycles completes with ERR_DATA.
module native_bus_decoder #(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int                       TIMEOUT    = 255,
  parameter logic [31:0]              ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       m_valid,
  input  logic                       m_instr,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic                       bus_err,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Wait count at which the slave has seen TIMEOUT cycles of s_valid
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic [IDXW-1:0]         sel;
  logic [CW-1:0]           wait_cnt;

  logic                    hit;
  logic [IDXW-1:0]         hit_idx;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic                    unmapped;
  logic                    timeout_hit;
  logic                    err_evt;
  logic [31:0]             err_evt_addr;

  // The instruction/data distinction plays no part in routing
  logic unused_instr;
  assign unused_instr = m_instr;

  // Address decode; scanning from the top down lets the lowest matching index win
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
    if (hit) begin
      hit_onehot[hit_idx] = 1'b1;
    end
  end

  assign sel_ready    = s_ready[sel];
  assign sel_rdata    = s_rdata[32*sel +: 32];
  assign unmapped     = (state == IDLE) && m_valid && !hit;
  assign timeout_hit  = (TIMEOUT != 0) && (state == ACCESS) && !sel_ready && (wait_cnt == CNT_LAST);
  assign err_evt      = unmapped || timeout_hit;
  // An unmapped address is still on m_addr; a timed-out one is held on s_addr
  assign err_evt_addr = unmapped ? m_addr : s_addr;

  // Transaction FSM: accept, wait for the selected slave, then pulse m_ready for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= '0;
      wait_cnt <= '0;
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      s_valid  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_ready <= 1'b0;
          if (m_valid) begin
            s_addr   <= m_addr;
            s_wdata  <= m_wdata;
            s_wstrb  <= m_wstrb;
            wait_cnt <= '0;
            if (hit) begin
              sel     <= hit_idx;
              s_valid <= hit_onehot;
              state   <= ACCESS;
            end else begin
              m_rdata <= ERR_DATA;
              m_ready <= 1'b1;
              state   <= RESP;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            m_rdata <= sel_rdata;
            s_valid <= '0;
            m_ready <= 1'b1;
            state   <= RESP;
          end else if (timeout_hit) begin
            m_rdata <= ERR_DATA;
            s_valid <= '0;
            m_ready <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          m_ready <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          m_ready <= 1'b0;
          s_valid <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; keeps the first faulting address until cleared, a same-cycle error beats the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else if (err_evt) begin
      bus_err <= 1'b1;
      if (!bus_err || err_clr) begin
        err_addr <= err_evt_addr;
      end
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

endmodule
